// File: rtl/rv32_alu.sv
// RV32I integer ALU: combinational result/zero/illegal plus a one-cycle registered copy.
// Define RV32_ALU_MINMAX_EN to add the Zbb MIN/MINU/MAX/MAXU operations.
module rv32_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic [3:0]      operation,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic [XLEN-1:0] result_q,
   output logic            zero_q,
   output logic            illegal_q
);

   generate
      if (XLEN != 32) begin : g_bad_xlen
         $error("rv32_alu: only XLEN = 32 is supported");
      end
   endgenerate

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
`ifdef RV32_ALU_MINMAX_EN
   localparam logic [3:0] OP_MIN  = 4'b1010;
   localparam logic [3:0] OP_MINU = 4'b1011;
   localparam logic [3:0] OP_MAX  = 4'b1110;
   localparam logic [3:0] OP_MAXU = 4'b1111;
`endif

   logic [4:0]      shamt_s;
   logic            lt_signed_s;
   logic            lt_unsigned_s;
   logic [XLEN-1:0] result_s;
   logic            illegal_s;

   // Only the low five bits of operand2 matter for shifts; bit 5 and up are ignored.
   assign shamt_s       = operand2[4:0];
   assign lt_signed_s   = $signed(operand1) < $signed(operand2);
   assign lt_unsigned_s = operand1 < operand2;

   // Operation decode; unsupported encodings give a zero result and flag illegal.
   always_comb begin
      result_s  = {XLEN{1'b0}};
      illegal_s = 1'b0;
      case (operation)
         OP_ADD:  result_s = operand1 + operand2;
         OP_SUB:  result_s = operand1 - operand2;
         OP_SLL:  result_s = operand1 << shamt_s;
         OP_SLT:  result_s = {{(XLEN-1){1'b0}}, lt_signed_s};
         OP_SLTU: result_s = {{(XLEN-1){1'b0}}, lt_unsigned_s};
         OP_XOR:  result_s = operand1 ^ operand2;
         OP_SRL:  result_s = operand1 >> shamt_s;
         OP_SRA:  result_s = $signed(operand1) >>> shamt_s;
         OP_OR:   result_s = operand1 | operand2;
         OP_AND:  result_s = operand1 & operand2;
`ifdef RV32_ALU_MINMAX_EN
         OP_MIN:  result_s = lt_signed_s   ? operand1 : operand2;
         OP_MINU: result_s = lt_unsigned_s ? operand1 : operand2;
         OP_MAX:  result_s = lt_signed_s   ? operand2 : operand1;
         OP_MAXU: result_s = lt_unsigned_s ? operand2 : operand1;
`endif
         default: begin
            result_s  = {XLEN{1'b0}};
            illegal_s = 1'b1;
         end
      endcase
   end

   assign result  = result_s;
   assign zero    = (result_s == {XLEN{1'b0}});
   assign illegal = illegal_s;

   // Pipeline copy of the combinational outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q  <= {XLEN{1'b0}};
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         result_q  <= result_s;
         zero_q    <= (result_s == {XLEN{1'b0}});
         illegal_q <= illegal_s;
      end
   end

endmodule

// File: tb/tb_rv32_alu.sv
// Scoreboard bench for rv32_alu: directed vectors queue their expected response,
// a monitor checks the combinational outputs and then the registered copy one edge later.
module tb_rv32_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] operand1 = 32'h0;
   logic [31:0] operand2 = 32'h0;
   logic [3:0]  operation = 4'b0000;
   logic [31:0] result, result_q;
   logic        zero, illegal, zero_q, illegal_q;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        il;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   rv32_alu dut (
      .clk(clk), .rst_n(rst_n), .operand1(operand1), .operand2(operand2),
      .operation(operation), .result(result), .zero(zero), .illegal(illegal),
      .result_q(result_q), .zero_q(zero_q), .illegal_q(illegal_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   task automatic issue(input logic rst, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input logic ei, input string nm);
      exp_t e;
      @(posedge clk);
      #2;
      rst_n     = rst;
      operation = op;
      operand1  = a;
      operand2  = b;
      e.res = er;
      e.z   = ez;
      e.il  = ei;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: combinational check at negedge, registered check just after the next posedge.
   initial begin
      exp_t  pend;
      string pname;
      logic  pend_valid;
      logic  rst_seen;
      pend_valid = 1'b0;
      pname = "idle";
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            pend  = exp_q.pop_front();
            pname = name_q.pop_front();
            pend_valid = 1'b1;
            chk({pname, ".result"},  result,            pend.res);
            chk({pname, ".zero"},    {31'h0, zero},     {31'h0, pend.z});
            chk({pname, ".illegal"}, {31'h0, illegal},  {31'h0, pend.il});
         end else begin
            pend_valid = 1'b0;
         end
         @(posedge clk);
         rst_seen = rst_n;
         #1;
         if (!rst_seen) begin
            chk({pname, ".rst.result_q"},  result_q,              32'h0);
            chk({pname, ".rst.zero_q"},    {31'h0, zero_q},       32'h0);
            chk({pname, ".rst.illegal_q"}, {31'h0, illegal_q},    32'h0);
         end else if (pend_valid) begin
            chk({pname, ".result_q"},  result_q,              pend.res);
            chk({pname, ".zero_q"},    {31'h0, zero_q},       {31'h0, pend.z});
            chk({pname, ".illegal_q"}, {31'h0, illegal_q},    {31'h0, pend.il});
         end else begin
            pend_valid = 1'b0;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      issue(1'b1, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, "add_ovf");
      issue(1'b1, 4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, "sub_wrap");
      issue(1'b1, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, "add_zero");
      issue(1'b1, 4'b1000, 32'h00000009, 32'h00000004, 32'h00000005, 1'b0, 1'b0, "sub_pos");
      issue(1'b1, 4'b0010, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "slt_neg");
      issue(1'b1, 4'b0011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, "sltu_big");
      issue(1'b1, 4'b0010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, "slt_eq");
      issue(1'b1, 4'b0011, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b0, "sltu_lt");
      issue(1'b1, 4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, "sll_31");
      issue(1'b1, 4'b0001, 32'h00000001, 32'hFFFFFFE1, 32'h00000002, 1'b0, 1'b0, "sll_hi_ign");
      issue(1'b1, 4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, "srl_4");
      issue(1'b1, 4'b1101, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, "sra_neg");
      issue(1'b1, 4'b1101, 32'h40000000, 32'h00000004, 32'h04000000, 1'b0, 1'b0, "sra_pos");
      issue(1'b1, 4'b0101, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, "srl_32");
      issue(1'b1, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, "xor");
      issue(1'b1, 4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, "or");
      issue(1'b1, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, "and");
      issue(1'b1, 4'b1001, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "ill_1001");
      issue(1'b1, 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, "ill_1100");
`ifdef RV32_ALU_MINMAX_EN
      issue(1'b1, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, "min");
      issue(1'b1, 4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "minu");
      issue(1'b1, 4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "max");
      issue(1'b1, 4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, "maxu");
`else
      issue(1'b1, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "ill_1010");
      issue(1'b1, 4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "ill_1011");
      issue(1'b1, 4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "ill_1110");
      issue(1'b1, 4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "ill_1111");
`endif
      // Registered path: capture, reset mid-stream, then first capture after release.
      issue(1'b1, 4'b0000, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, "add_2_3");
      issue(1'b0, 4'b0100, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, "xor_in_rst");
      issue(1'b1, 4'b0110, 32'h00000004, 32'h00000001, 32'h00000005, 1'b0, 1'b0, "or_after_rst");
      issue(1'b1, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, "add_zero_q");

      repeat (3) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- Integer ALU for the RV32I execute stage. Computes one of ten base-ISA operations on two 32-bit operands.
- result and zero are purely combinational, valid within the same evaluation with no clock dependency.
- A one-cycle registered copy (result_q, zero_q, illegal_q) is provided for pipelined consumers, clocked by clk and cleared by synchronous active-low reset.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; any other value is a configuration error.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous active-low reset; sampled on rising clk edge
- operand1  input  32  first operand (rs1 / PC)
- operand2  input  32  second operand (rs2 / immediate); bits [4:0] are the shift amount
- operation  input  4  operation select, {funct7[5], funct3} encoding
- result  output  32  combinational ALU result
- zero  output  1  combinational, 1 when result == 0
- illegal  output  1  combinational, 1 when operation is an unsupported encoding
- result_q  output  32  result registered one cycle
- zero_q  output  1  zero registered one cycle
- illegal_q  output  1  illegal registered one cycle

Behaviour:
- Operation encodings:
  - 0000 ADD: operand1 + operand2, modulo 2^32, carry discarded.
  - 1000 SUB: operand1 - operand2, modulo 2^32, borrow discarded.
  - 0001 SLL: operand1 << operand2[4:0].
  - 0010 SLT: 32'h1 if signed(operand1) < signed(operand2), else 32'h0.
  - 0011 SLTU: 32'h1 if unsigned(operand1) < unsigned(operand2), else 32'h0.
  - 0100 XOR.
  - 0101 SRL: logical right shift by operand2[4:0], zero fill.
  - 1101 SRA: arithmetic right shift by operand2[4:0], sign fill from operand1[31].
  - 0110 OR.
  - 0111 AND.
- Shifts use only operand2[4:0]; operand2[31:5] are ignored (shift by 32 behaves as shift by 0).
- Unsupported encodings (1001, 1010, 1011, 1100, 1110, 1111 without the optional feature): result = 32'h0, illegal = 1, zero = 1.
- Combinational outputs have no reset dependency. No X propagates from known inputs. Full-case decode, no latches.
- Registered outputs:
  - On a rising clk edge with rst_n = 0: result_q = 0, zero_q = 0, illegal_q = 0.
  - Otherwise they capture result, zero and illegal on each rising edge; latency is exactly 1 cycle.
  - Reset asserted mid-stream clears them on that edge; the first capture after rst_n returns high occurs at the next edge.
- Boundary conditions:
  - 0x7FFFFFFF + 1 = 0x80000000 (no overflow flag).
  - 0x00000000 - 1 = 0xFFFFFFFF.
  - SLT treats 0x80000000 as the most negative value.

Optional Feature:
- Macro RV32_ALU_MINMAX_EN.
- When defined, Zbb min/max ops are added:
  - 1010 MIN (signed minimum)
  - 1011 MINU (unsigned minimum)
  - 1110 MAX (signed maximum)
  - 1111 MAXU (unsigned maximum)
  - These four encodings do not assert illegal.
- When undefined, those four encodings are illegal (result 0, illegal 1). All other behaviour is identical.

Test Plan:
- Arithmetic: ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000; SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF; ADD 0xFFFFFFFF + 0x00000001 -> 0x00000000 with zero = 1.
- Compares: SLT 0x80000000 vs 0x00000001 -> 0x00000001; SLTU on the same operands -> 0x00000000; SLT on equal operands -> 0x00000000.
- Shifts: SLL 0x00000001 by 0x0000001F -> 0x80000000; SRL 0x80000000 by 4 -> 0x08000000; SRA 0x80000000 by 4 -> 0xF8000000; SRL by 0x00000020 -> operand1 unchanged.
- Logic: operands 0xF0F0F0F0 and 0x0FF00FF0 -> XOR 0xFF00FF00, OR 0xFFF0FFF0, AND 0x00F000F0.
- Illegal and min/max: operation 1001 -> result 0x00000000, illegal = 1. Operation 1010 with operands 0xFFFFFFFF, 0x00000001 -> illegal = 1 without the macro; with the macro -> result 0xFFFFFFFF, illegal = 0.
- Registered path: hold rst_n = 0 for 2 edges -> result_q = 0. Release, apply ADD 2 + 3 -> result_q = 0x00000005 one edge later. Assert rst_n = 0 mid-stream -> result_q = 0 at that edge.
